uart_kbd_ctrl: RTL and testbench

- Sequences the UART receive datapath into the LC-3 keyboard device registers KBSR and KBDR.
- Converts each completed-frame indication from the UART receiver into one FIFO push.
- Presents FIFO state through KBSR and FIFO data through KBDR to the CPU memory-mapped I/O port.
- Raises the keyboard interrupt when enabled and data is pending; tracks overrun when a byte arrives with the FIFO full.

---
 rtl/uart_kbd_ctrl.sv | 142 ++++++++++++++
 tb/tb_uart_kbd_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_kbd_ctrl.sv
// uart_kbd_ctrl: bridges the UART receiver into the LC-3 keyboard registers.
// Each rising edge of rx_done pushes one byte into a small FIFO. The CPU reads
// FIFO state through KBSR (RDY/IE/OVR) and pops bytes through KBDR.
module uart_kbd_ctrl #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             rx_done,
  input  logic [7:0]       rx_data,
  input  logic             cpu_sel,
  input  logic             cpu_rd,
  input  logic             cpu_wr,
  input  logic [15:0]      cpu_wdata,
  output logic [15:0]      cpu_rdata,
  output logic             cpu_rvalid,
  output logic             kbd_irq,
  output logic [PTR_W:0]   fifo_count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // FIFO storage and bookkeeping
  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  // Status and CPU-facing registers
  logic             ie_q, ie_d;
  logic             ovr_q, ovr_d;
  logic             rx_done_q;
  logic [15:0]      rdata_q, rdata_d;
  logic             rvalid_q;
  logic             irq_q, irq_d;

  // Decoded per-cycle events
  logic             push_req;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             push_ok;
  logic             overflow;
  logic             kbsr_wr;

  // Only bits 14 and 13 of a KBSR write carry meaning.
  logic             unused_wdata;
  assign unused_wdata = ^{cpu_wdata[15], cpu_wdata[12:0]};

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  // One push per frame: only the rising edge of rx_done counts.
  assign push_req   = rx_done & ~rx_done_q;
  assign pop        = cpu_rd & cpu_sel & ~fifo_empty;
  // A same-cycle pop frees a slot, so a full FIFO still accepts the byte.
  assign push_ok    = push_req & (~fifo_full | pop);
  assign overflow   = push_req & fifo_full & ~pop;
  // A read in the same cycle wins over a write; KBDR writes are ignored.
  assign kbsr_wr    = cpu_wr & ~cpu_rd & ~cpu_sel;

  // Next-state for pointers, count, status bits, read data and interrupt
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ie_d     = ie_q;
    ovr_d    = ovr_q;
    rdata_d  = rdata_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (kbsr_wr) begin
      ie_d = cpu_wdata[14];
    end
    // Overrun set takes priority over a same-cycle software clear.
    if (overflow) begin
      ovr_d = 1'b1;
    end else if (kbsr_wr && cpu_wdata[13]) begin
      ovr_d = 1'b0;
    end

    // Read data reflects the state before this cycle's push/pop.
    if (cpu_rd) begin
      if (cpu_sel) begin
        rdata_d = fifo_empty ? 16'h0000 : {8'h00, mem_q[rd_ptr_q]};
      end else begin
        rdata_d = {~fifo_empty, ie_q, ovr_q, 13'h0000};
      end
    end

    irq_d = ie_d & (count_d != '0);
  end

  // FIFO byte storage; contents are discarded by resetting the pointers.
  always_ff @(posedge sys_clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ie_q      <= 1'b0;
      ovr_q     <= 1'b0;
      rx_done_q <= 1'b0;
      rdata_q   <= 16'h0000;
      rvalid_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ie_q      <= ie_d;
      ovr_q     <= ovr_d;
      rx_done_q <= rx_done;
      rdata_q   <= rdata_d;
      rvalid_q  <= cpu_rd;
      irq_q     <= irq_d;
    end
  end

  assign cpu_rdata  = rdata_q;
  assign cpu_rvalid = rvalid_q;
  assign kbd_irq    = irq_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_kbd_ctrl.sv
// Testbench for uart_kbd_ctrl: a vector table, hand-written corner sequences
// and randomized traffic, all checked against a queue-based reference model.
module tb_uart_kbd_ctrl;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic           sys_clk = 1'b0;
  logic           sys_rst_n;
  logic           rx_done;
  logic [7:0]     rx_data;
  logic           cpu_sel;
  logic           cpu_rd;
  logic           cpu_wr;
  logic [15:0]    cpu_wdata;
  logic [15:0]    cpu_rdata;
  logic           cpu_rvalid;
  logic           kbd_irq;
  logic [PTR_W:0] fifo_count;

  uart_kbd_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .cpu_sel    (cpu_sel),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .kbd_irq    (kbd_irq),
    .fifo_count (fifo_count)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the FIFO as a queue plus the status bits
  logic [7:0]  mq[$];
  bit          m_ie;
  bit          m_ovr;
  bit          m_prev;
  bit          exp_rvalid;
  logic [15:0] exp_rdata;

  typedef struct {
    bit          done;
    logic [7:0]  d;
    bit          sel;
    bit          rd;
    bit          wr;
    logic [15:0] wd;
    bit          e_rvalid;
    logic [15:0] e_rdata;
    int          e_count;
    bit          e_irq;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_ie   = 1'b0;
    m_ovr  = 1'b0;
    m_prev = 1'b0;
  endtask

  // Apply one clock cycle of inputs, advance the model, compare outputs.
  task automatic cycle(input bit done, input logic [7:0] d, input bit sel,
                       input bit rd, input bit wr, input logic [15:0] wd);
    bit push, pop, ovr_set, clr;
    rx_done   = done;
    rx_data   = d;
    cpu_sel   = sel;
    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_wdata = wd;
    @(posedge sys_clk);
    push   = done && !m_prev;
    m_prev = done;
    pop    = 1'b0;
    exp_rvalid = rd;
    if (rd) begin
      if (!sel) begin
        exp_rdata = {mq.size() != 0, m_ie, m_ovr, 13'h0000};
      end else if (mq.size() > 0) begin
        exp_rdata = {8'h00, mq[0]};
        pop = 1'b1;
      end else begin
        exp_rdata = 16'h0000;
      end
    end
    clr = 1'b0;
    if (wr && !rd && !sel) begin
      m_ie = wd[14];
      clr  = wd[13];
    end
    ovr_set = push && (mq.size() == DEPTH) && !pop;
    if (pop) void'(mq.pop_front());
    if (push && !ovr_set) mq.push_back(d);
    if (ovr_set) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    #1;
    check("rvalid", cpu_rvalid, exp_rvalid);
    if (exp_rvalid) check("rdata", cpu_rdata, exp_rdata);
    check("count", fifo_count, mq.size());
    check("irq", kbd_irq, m_ie && (mq.size() != 0));
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    rx_done   = 1'b0;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    model_clear();
  endtask

  task automatic push_byte(input logic [7:0] b);
    cycle(1'b1, b, 1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    bit cur_done;
    sys_rst_n = 1'b0;
    rx_done   = 1'b0;
    rx_data   = 8'h00;
    cpu_sel   = 1'b0;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    cpu_wdata = 16'h0;
    model_clear();

    //           done d      sel  rd   wr   wd        rv   rdata     cnt irq
    tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h4000, 1'b0, 16'h0000, 0, 1'b0};
    tbl[1] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1, 1'b1};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0055, 0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h4000, 0, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h2000, 1'b0, 16'h0000, 0, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 0, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 0, 1'b0};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 16'h4000, 1'b1, 16'h0000, 0, 1'b0};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 0, 1'b0};

    // Reset state
    do_reset();
    check("rst_rdata", cpu_rdata, 16'h0000);
    check("rst_rvalid", cpu_rvalid, 1'b0);
    check("rst_irq", kbd_irq, 1'b0);
    check("rst_count", fifo_count, 0);

    // Vector table: IE / interrupt / write-ignore behaviour
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].done, tbl[i].d, tbl[i].sel, tbl[i].rd, tbl[i].wr, tbl[i].wd);
      check("tbl_rvalid", cpu_rvalid, tbl[i].e_rvalid);
      if (tbl[i].e_rvalid) check("tbl_rdata", cpu_rdata, tbl[i].e_rdata);
      check("tbl_count", fifo_count, tbl[i].e_count);
      check("tbl_irq", kbd_irq, tbl[i].e_irq);
      $display("vec %0d: rvalid=%b rdata=%h count=%0d irq=%b",
               i, cpu_rvalid, cpu_rdata, fifo_count, kbd_irq);
    end

    // rx_done held high for 300 cycles gives exactly one push
    do_reset();
    repeat (300) cycle(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 16'h0);
    check("hold_count", fifo_count, 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0);
    check("hold_rdata", cpu_rdata, 16'h0041);
    check("hold_count_after", fifo_count, 0);
    $display("seq hold: rdata=%h count=%0d", cpu_rdata, fifo_count);

    // Fill, overflow, drain in order, then an empty read
    do_reset();
    for (int i = 0; i < 9; i++) push_byte(8'h10 + 8'(i));
    check("ovf_count", fifo_count, 8);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0);
    check("ovf_kbsr", cpu_rdata, 16'hA000);
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0);
      check("drain_rdata", cpu_rdata, (i < 8) ? (16'h0010 + 16'(i)) : 16'h0000);
    end
    $display("seq overflow/drain: last rdata=%h count=%0d", cpu_rdata, fifo_count);

    // Full FIFO: push and pop in the same cycle
    do_reset();
    for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i));
    cycle(1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 16'h0);
    check("fullpp_rdata", cpu_rdata, 16'h0020);
    check("fullpp_count", fifo_count, 8);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0);
    check("fullpp_kbsr", cpu_rdata, 16'h8000);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0);
    check("fullpp_tail", cpu_rdata, 16'h0099);
    $display("seq full push+pop: tail rdata=%h", cpu_rdata);

    // Empty FIFO: push and read in the same cycle
    do_reset();
    cycle(1'b1, 8'h7E, 1'b1, 1'b1, 1'b0, 16'h0);
    check("emptypp_rdata", cpu_rdata, 16'h0000);
    check("emptypp_count", fifo_count, 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0);
    check("emptypp_next", cpu_rdata, 16'h007E);
    $display("seq empty push+pop: rdata=%h", cpu_rdata);

    // Asynchronous reset mid-stream
    do_reset();
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h4000);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("arst_rdata", cpu_rdata, 16'h0000);
    check("arst_rvalid", cpu_rvalid, 1'b0);
    check("arst_irq", kbd_irq, 1'b0);
    check("arst_count", fifo_count, 0);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    model_clear();
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0);
    check("arst_kbsr", cpu_rdata, 16'h0000);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0);
    check("arst_kbdr", cpu_rdata, 16'h0000);
    $display("seq async reset: count=%0d", fifo_count);

    // Randomized traffic against the model
    do_reset();
    cur_done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) cur_done = !cur_done;
      cycle(cur_done, 8'($urandom), 1'($urandom), $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0, 16'($urandom));
    end
    $display("random: done, final count=%0d", fifo_count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
